// File: rtl/pixel_fb_writer_if.sv
// Rasterizer pixel stream plus framebuffer write handshake, bundled for the writer stage.
interface pixel_fb_writer_if #(
    parameter int CORDW = 8,
    parameter int ADDRW = 15
);
    logic             in_valid;
    logic [CORDW-1:0] in_x;
    logic [CORDW-1:0] in_y;
    logic [23:0]      in_color;
    logic             in_done;
    logic             mem_req;
    logic [ADDRW-1:0] mem_addr;
    logic [15:0]      mem_data;
    logic             mem_ack;

    modport master (
        output in_valid, in_x, in_y, in_color, in_done, mem_ack,
        input  mem_req, mem_addr, mem_data
    );

    modport slave (
        input  in_valid, in_x, in_y, in_color, in_done, mem_ack,
        output mem_req, mem_addr, mem_data
    );
endinterface

// File: rtl/pixel_fb_writer.sv
// Clips, converts and queues rasterizer pixels, then writes them one per req/ack.
// Push-to-req is two edges; the pixel input has no backpressure, so a full FIFO drops and flags overflow.
module pixel_fb_writer #(
    parameter int CORDW = 8,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120,
    parameter int ADDRW = 15,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    pixel_fb_writer_if.slave   bus,
    input  logic               clear_stats,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow,
    output logic [15:0]        pix_count,
    output logic [15:0]        clip_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = ADDRW + 16;
    localparam logic [CORDW:0]   FB_W_C = (CORDW+1)'(FB_W);
    localparam logic [CORDW:0]   FB_H_C = (CORDW+1)'(FB_H);
    localparam logic [ADDRW-1:0] FB_W_A = ADDRW'(FB_W);
    localparam logic [AW:0]      FULL_C = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t           state, state_nxt;
    logic [EW-1:0]    fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             empty, full, in_range, push, pop;
    logic [ADDRW-1:0] addr_calc;
    logic [15:0]      rgb565;
    logic             done_d, done_rise, done_pending;

    assign in_range  = ({1'b0, bus.in_x} < FB_W_C) && ({1'b0, bus.in_y} < FB_H_C);
    assign addr_calc = ADDRW'(bus.in_y) * FB_W_A + ADDRW'(bus.in_x);
    assign rgb565    = {bus.in_color[23:19], bus.in_color[15:10], bus.in_color[7:3]};
    assign empty     = (count == '0);
    assign full      = (count == FULL_C);
    // Fullness is judged on the start-of-cycle count, so a same-cycle pop does not rescue the pixel.
    assign push      = bus.in_valid && in_range && !full;
    assign done_rise = bus.in_done && !done_d;

    assign bus.mem_req = (state == REQ);
    assign busy        = !empty || (state == REQ) || done_pending;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (!empty) pop = 1'b1;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {addr_calc, rgb565};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                {bus.mem_addr, bus.mem_data} <= fifo_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_d       <= 1'b0;
            done_pending <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            done_d     <= bus.in_done;
            frame_done <= 1'b0;
            if (done_pending && empty && state == IDLE) begin
                frame_done   <= 1'b1;
                done_pending <= 1'b0;
            end
            // A new rise wins over a same-cycle completion so it is never lost.
            if (done_rise) done_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            overflow   <= 1'b0;
            pix_count  <= '0;
            clip_count <= '0;
        end else begin
            if (bus.in_valid && in_range && full) overflow <= 1'b1;
            if (bus.in_valid && !in_range && clip_count != 16'hFFFF)
                clip_count <= clip_count + 16'd1;
            if (state == REQ && bus.mem_ack && pix_count != 16'hFFFF)
                pix_count <= pix_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed self-checking bench for pixel_fb_writer with hand-computed addresses and colors.
module tb_pixel_fb_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear_stats;
    logic        busy, frame_done, overflow;
    logic [15:0] pix_count, clip_count;
    int          passed = 0;
    int          total  = 0;

    pixel_fb_writer_if #(.CORDW(8), .ADDRW(15)) bus ();

    pixel_fb_writer #(
        .CORDW(8), .FB_W(160), .FB_H(120), .ADDRW(15), .DEPTH(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear_stats (clear_stats),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .pix_count   (pix_count),
        .clip_count  (clip_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_color = '0;
        bus.in_done  = 1'b0;
        bus.mem_ack  = 1'b0;
        clear_stats  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_px(input int x, input int y, input logic [23:0] c);
        bus.in_valid = 1'b1;
        bus.in_x     = 8'(x);
        bus.in_y     = 8'(y);
        bus.in_color = c;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        total++; if ({frame_done, overflow, pix_count, clip_count} !== 34'd0)
            $display("FAIL reset_status got fd=%b ov=%b pix=%0d clip=%0d exp all 0", frame_done, overflow, pix_count, clip_count);
        else passed++;
        total++; if (bus.mem_addr !== 15'd0) $display("FAIL reset_addr got %0d exp 0", bus.mem_addr); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        bus.mem_ack = 1'b1;
        push_px(3, 2, 24'hFF8040);
        total++; if (bus.mem_req !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_queued got req=%b busy=%b exp req=0 busy=1", bus.mem_req, busy);
        else passed++;
        step();
        total++; if (bus.mem_req !== 1'b1) $display("FAIL single_req got %b exp 1", bus.mem_req); else passed++;
        total++; if (bus.mem_addr !== 15'd323) $display("FAIL single_addr got %0d exp 323", bus.mem_addr); else passed++;
        total++; if (bus.mem_data !== 16'hFC08) $display("FAIL single_data got %h exp fc08", bus.mem_data); else passed++;
        step();
        total++; if (bus.mem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_after got req=%b busy=%b exp 0 0", bus.mem_req, busy);
        else passed++;
        total++; if (pix_count !== 16'd1) $display("FAIL single_pix got %0d exp 1", pix_count); else passed++;
    endtask

    task automatic test_clip();
        do_reset();
        bus.mem_ack = 1'b1;
        push_px(160, 0, 24'h123456);
        push_px(0, 120, 24'h123456);
        push_px(5, 5, 24'h00FF00);
        step();
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 15'd805)
            $display("FAIL clip_addr got req=%b addr=%0d exp req=1 addr=805", bus.mem_req, bus.mem_addr);
        else passed++;
        total++; if (bus.mem_data !== 16'h07E0) $display("FAIL clip_data got %h exp 07e0", bus.mem_data); else passed++;
        step();
        step();
        total++; if (clip_count !== 16'd2) $display("FAIL clip_count got %0d exp 2", clip_count); else passed++;
        total++; if (pix_count !== 16'd1 || overflow !== 1'b0)
            $display("FAIL clip_pix got pix=%0d ov=%b exp pix=1 ov=0", pix_count, overflow);
        else passed++;
    endtask

    // One pixel sits in the engine while the 16-entry FIFO fills, so 17 are kept and 3 dropped.
    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 20; i++) push_px(i, 0, 24'h000000);
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else passed++;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 17; i++) begin
            total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 15'(i))
                $display("FAIL ovf_order got req=%b addr=%0d exp req=1 addr=%0d", bus.mem_req, bus.mem_addr, i);
            else passed++;
            step();
        end
        total++; if (bus.mem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL ovf_drain got req=%b busy=%b exp 0 0", bus.mem_req, busy);
        else passed++;
        total++; if (pix_count !== 16'd17) $display("FAIL ovf_pix got %0d exp 17", pix_count); else passed++;
    endtask

    task automatic test_done();
        int acks = 0, pulses = 0, acks_at = -1;
        logic hit;
        do_reset();
        for (int i = 0; i < 4; i++) push_px(10 + i, 1, 24'hABCDEF);
        for (int i = 0; i < 30; i++) begin
            bus.in_done = (i < 5);
            bus.mem_ack = (i % 2 == 1);
            hit = bus.mem_req && bus.mem_ack;
            step();
            if (hit) acks++;
            if (frame_done) begin
                pulses++;
                acks_at = acks;
            end
        end
        bus.mem_ack = 1'b0;
        total++; if (pulses !== 1) $display("FAIL done_pulses got %0d exp 1", pulses); else passed++;
        total++; if (acks_at !== 4) $display("FAIL done_timing got acks=%0d exp 4", acks_at); else passed++;
        total++; if (pix_count !== 16'd4 || busy !== 1'b0)
            $display("FAIL done_final got pix=%0d busy=%b exp 4 0", pix_count, busy);
        else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_px(200, 0, 24'h0);
        for (int i = 1; i <= 4; i++) push_px(i, 3, 24'h0);
        total++; if (bus.mem_req !== 1'b1) $display("FAIL mrst_pre got req=%b exp 1", bus.mem_req); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (bus.mem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL mrst_state got req=%b busy=%b exp 0 0", bus.mem_req, busy);
        else passed++;
        total++; if (pix_count !== 16'd0 || clip_count !== 16'd0)
            $display("FAIL mrst_cnt got pix=%0d clip=%0d exp 0 0", pix_count, clip_count);
        else passed++;
        bus.mem_ack = 1'b1;
        push_px(7, 9, 24'h0000FF);
        step();
        total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 15'd1447 || bus.mem_data !== 16'h001F)
            $display("FAIL mrst_new got req=%b addr=%0d data=%h exp 1 1447 001f", bus.mem_req, bus.mem_addr, bus.mem_data);
        else passed++;
        step();
        step();
        total++; if (bus.mem_req !== 1'b0 || pix_count !== 16'd1 || busy !== 1'b0)
            $display("FAIL mrst_after got req=%b pix=%0d busy=%b exp 0 1 0", bus.mem_req, pix_count, busy);
        else passed++;
    endtask

    task automatic test_clear_stats();
        do_reset();
        push_px(200, 0, 24'h0);
        bus.mem_ack = 1'b1;
        push_px(1, 1, 24'h0);
        step();
        step();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 17; i++) push_px(i, 2, 24'h0);
        total++; if (overflow !== 1'b0 || pix_count !== 16'd1 || clip_count !== 16'd1)
            $display("FAIL clr_pre got ov=%b pix=%0d clip=%0d exp 0 1 1", overflow, pix_count, clip_count);
        else passed++;
        clear_stats = 1'b1;
        push_px(20, 2, 24'h0);
        clear_stats = 1'b0;
        total++; if (overflow !== 1'b0 || pix_count !== 16'd0 || clip_count !== 16'd0)
            $display("FAIL clr_same got ov=%b pix=%0d clip=%0d exp 0 0 0", overflow, pix_count, clip_count);
        else passed++;
        push_px(21, 2, 24'h0);
        total++; if (overflow !== 1'b1) $display("FAIL clr_reovf got %b exp 1", overflow); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_clip();
        test_overflow();
        test_done();
        test_mid_reset();
        test_clear_stats();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
